// File: rtl/sequenciador_apresentacao.sv
// sequenciador_apresentacao
// Presentation sequencer for the memory game. On a start request it walks the
// sequence RAM from address 0 up to the captured round index. Each stored
// value is shown on the LEDs with the buzzer on for T_ON cycles. A blank gap
// of T_OFF cycles separates consecutive values. A one-cycle completion pulse
// ends the run. While pausa is high the sequence freezes in place.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-low
//   iniciar      in   start request, honoured only in IDLE with pausa low
//   pausa        in   pause level; freezes LOAD/SHOW/GAP
//   rodada[3:0]  in   last address to present, captured at start
//   dado[3:0]    in   RAM read data for endereco
//   endereco[3:0] out RAM address
//   leds[3:0]    out  LED drive (value being shown)
//   pulso_buzzer out  high while a value is shown
//   ocupado      out  high in every state except IDLE
//   pausado      out  high while frozen by pausa
//   fim          out  one-cycle completion pulse
//   db_estado[3:0] out state code (IDLE=0 LOAD=1 SHOW=2 GAP=3 FIM=4)
module sequenciador_apresentacao #(
  parameter int unsigned CLOCK_FREQ = 5000,
  parameter int unsigned APRESENTA  = 2,
  parameter int unsigned MOSTRA     = CLOCK_FREQ / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausa,
  input  logic [3:0] rodada,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       pulso_buzzer,
  output logic       ocupado,
  output logic       pausado,
  output logic       fim,
  output logic [3:0] db_estado
);

  localparam int unsigned T_ON  = APRESENTA * CLOCK_FREQ;
  localparam int unsigned T_OFF = MOSTRA;
  localparam int unsigned T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CW-1:0] ON_LAST  = CW'(T_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(T_OFF - 1);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    LOAD = 4'd1,
    SHOW = 4'd2,
    GAP  = 4'd3,
    FIM  = 4'd4
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    end_q, end_d;
  logic [3:0]    rod_q, rod_d;
  logic [3:0]    val_q, val_d;
  logic          pause_q, pause_d;
  logic [3:0]    leds_q, leds_d;
  logic          buz_q, buz_d;
  logic          ocup_q, ocup_d;
  logic          fim_q, fim_d;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    end_d    = end_q;
    rod_d    = rod_q;
    val_d    = val_q;
    pause_d  = 1'b0;

    case (estado_q)
      IDLE: begin
        cnt_d = '0;
        end_d = '0;
        if (iniciar && !pausa) begin
          estado_d = LOAD;
          rod_d    = rodada;
        end
      end
      LOAD: begin
        if (pausa) begin
          pause_d = 1'b1;
        end else begin
          val_d    = dado;
          cnt_d    = '0;
          estado_d = SHOW;
        end
      end
      SHOW: begin
        if (pausa) begin
          pause_d = 1'b1;
        end else if (cnt_q == ON_LAST) begin
          cnt_d    = '0;
          estado_d = (end_q == rod_q) ? FIM : GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (pausa) begin
          pause_d = 1'b1;
        end else if (cnt_q == OFF_LAST) begin
          cnt_d    = '0;
          end_d    = end_q + 4'd1;
          estado_d = LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIM: begin
        cnt_d    = '0;
        end_d    = '0;
        estado_d = IDLE;
      end
      default: begin
        cnt_d    = '0;
        end_d    = '0;
        estado_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so every output is a flop.
    leds_d = (estado_d == SHOW && !pause_d) ? val_d : '0;
    buz_d  = (estado_d == SHOW) && !pause_d;
    ocup_d = (estado_d != IDLE);
    fim_d  = (estado_d == FIM);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      end_q    <= '0;
      rod_q    <= '0;
      val_q    <= '0;
      pause_q  <= 1'b0;
      leds_q   <= '0;
      buz_q    <= 1'b0;
      ocup_q   <= 1'b0;
      fim_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      end_q    <= end_d;
      rod_q    <= rod_d;
      val_q    <= val_d;
      pause_q  <= pause_d;
      leds_q   <= leds_d;
      buz_q    <= buz_d;
      ocup_q   <= ocup_d;
      fim_q    <= fim_d;
    end
  end

  assign endereco     = end_q;
  assign leds         = leds_q;
  assign pulso_buzzer = buz_q;
  assign ocupado      = ocup_q;
  assign pausado      = pause_q;
  assign fim          = fim_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_sequenciador_apresentacao.sv
// Testbench for sequenciador_apresentacao with T_ON=8, T_OFF=2.
// Sequence RAM modelled as value 1,2,4,8 repeating by address.
module tb_sequenciador_apresentacao;

  localparam int T_ON  = 8;
  localparam int T_OFF = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       pausa = 1'b0;
  logic [3:0] rodada = 4'd0;
  logic [3:0] dado;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       pulso_buzzer;
  logic       ocupado;
  logic       pausado;
  logic       fim;
  logic [3:0] db_estado;

  sequenciador_apresentacao #(
    .CLOCK_FREQ(4),
    .APRESENTA (2),
    .MOSTRA    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .iniciar     (iniciar),
    .pausa       (pausa),
    .rodada      (rodada),
    .dado        (dado),
    .endereco    (endereco),
    .leds        (leds),
    .pulso_buzzer(pulso_buzzer),
    .ocupado     (ocupado),
    .pausado     (pausado),
    .fim         (fim),
    .db_estado   (db_estado)
  );

  always #5 clock = ~clock;

  assign dado = 4'b0001 << endereco[1:0];

  typedef struct packed {
    logic [3:0] leds;
    logic       buz;
    logic [3:0] endr;
    logic       ocup;
    logic       paus;
    logic       fm;
    logic [3:0] db;
  } obs_t;

  obs_t cur;
  assign cur = {leds, pulso_buzzer, endereco, ocupado, pausado, fim, db_estado};

  obs_t exp_q[$];
  int   ntests = 0;
  int   nfail  = 0;
  int   ncyc;
  int   pause_at;
  int   pause_len;

  function automatic obs_t mk(int l, int b, int a, int o, int p, int f, int d);
    obs_t e;
    e.leds = 4'(l);
    e.buz  = 1'(b);
    e.endr = 4'(a);
    e.ocup = 1'(o);
    e.paus = 1'(p);
    e.fm   = 1'(f);
    e.db   = 4'(d);
    return e;
  endfunction

  function automatic int memv(int a);
    return 1 << (a % 4);
  endfunction

  task automatic check(input string tag, input obs_t e);
    ntests++;
    assert (cur === e) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, cur, e);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Pushes one expected cycle; after the cycle where pausa is first driven,
  // the following frozen cycles repeat it with LEDs/buzzer blanked.
  task automatic push_cyc(input obs_t e);
    obs_t f;
    exp_q.push_back(e);
    ncyc++;
    if (ncyc == pause_at) begin
      f = e;
      f.leds = '0;
      f.buz  = 1'b0;
      f.paus = 1'b1;
      for (int i = 0; i < pause_len; i++) begin
        exp_q.push_back(f);
      end
    end
  endtask

  task automatic run(input int r, input int p, input int plen, input int rst_at,
                     input int spur_at, input bit fim_pause);
    obs_t e;
    int   n;
    int   fim_n;
    int   fim_seen;
    int   exp_fim;
    exp_q.delete();
    ncyc      = 0;
    pause_at  = p;
    pause_len = plen;
    for (int a = 0; a <= r; a++) begin
      push_cyc(mk(0, 0, a, 1, 0, 0, 1));
      for (int i = 0; i < T_ON; i++) push_cyc(mk(memv(a), 1, a, 1, 0, 0, 2));
      if (a < r) begin
        for (int i = 0; i < T_OFF; i++) push_cyc(mk(0, 0, a, 1, 0, 0, 3));
      end
    end
    push_cyc(mk(0, 0, r, 1, 0, 1, 4));
    push_cyc(mk(0, 0, 0, 0, 0, 0, 0));
    fim_n   = exp_q.size() - 1;
    exp_fim = (r + 1) * (1 + T_ON) + r * T_OFF + 1 + plen;
    if (rst_at > 0) begin
      while (exp_q.size() > rst_at) void'(exp_q.pop_back());
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      exp_fim = 0;
    end

    @(negedge clock);
    rodada  = 4'(r);
    iniciar = 1'b1;
    n        = 1;
    fim_seen = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      if (fim === 1'b1) fim_seen = n;
      check($sformatf("r%0d_cyc%0d", r, n), e);
      iniciar = (spur_at > 0 && n >= spur_at && n < spur_at + 3);
      if (iniciar) rodada = 4'd5;
      pausa = (plen > 0 && n >= p && n < p + plen) || (fim_pause && n == fim_n);
      reset = !(rst_at > 0 && n == rst_at);
      n++;
    end
    iniciar = 1'b0;
    pausa   = 1'b0;
    reset   = 1'b1;
    check_int($sformatf("r%0d_fim_cycle", r), fim_seen, exp_fim);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles, then idle with no start.
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check($sformatf("reset_%0d", i), mk(0, 0, 0, 0, 0, 0, 0));
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("idle_%0d", i), mk(0, 0, 0, 0, 0, 0, 0));
    end

    // pausa blocks a start request in IDLE.
    iniciar = 1'b1;
    pausa   = 1'b1;
    @(negedge clock);
    check("idle_pause_blocks", mk(0, 0, 0, 0, 0, 0, 0));
    iniciar = 1'b0;
    pausa   = 1'b0;

    // Single value; pausa during FIM is ignored.
    run(0, 0, 0, 0, 0, 1'b1);
    // Three values, unpaused.
    run(2, 0, 0, 0, 0, 1'b0);
    // Pause 5 cycles mid-SHOW of address 1.
    run(2, 15, 5, 0, 0, 1'b0);
    // Restart request and rodada change mid-sequence are ignored.
    run(2, 0, 0, 0, 5, 1'b0);
    // Reset during GAP of address 1.
    run(2, 0, 0, 21, 0, 1'b0);
    // Full 16-value run, no address wrap.
    run(15, 0, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
